// File: rtl/alu_issue_stage.sv
// MIPS ALU issue stage: decodes one instruction per cycle into an ALU op and operands, queued in a 2-entry skid buffer.
// Optional build macro ALU_ISSUE_TRAP_EN: an illegal instruction latches illegal high and stalls intake until rst.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        control_in,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] store_data,
    output logic [4:0]        dest_reg,
    output logic              reg_wr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [3:0]        ctrl;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] sd;
        logic [4:0]        dest;
        logic              wr;
        logic              rd;
        logic              mw;
    } entry_t;

    state_t     state_reg;
    entry_t     ent_reg [DEPTH];
    logic       illegal_reg;
    entry_t     dec_next;
    logic       legal_next;
    logic       fire_in;
    logic       accept;
    logic       drain;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rt_idx;
    logic [4:0]        rd_idx;
    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] zext_imm;
    logic [DATA_W-1:0] zext_shamt;
    logic              unused_rs_idx;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign rt_idx        = instr[20:16];
    assign rd_idx        = instr[15:11];
    assign sext_imm      = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign zext_imm      = {{(DATA_W-16){1'b0}}, instr[15:0]};
    assign zext_shamt    = {{(DATA_W-5){1'b0}}, instr[10:6]};
    // The rs index is resolved upstream; only its register value arrives here.
    assign unused_rs_idx = ^instr[25:21];

    always_comb begin
        dec_next   = '0;
        legal_next = 1'b0;
        if (opcode == 6'b000000) begin
            dec_next.a    = rs_data;
            dec_next.b    = rt_data;
            dec_next.dest = rd_idx;
            dec_next.wr   = 1'b1;
            legal_next    = 1'b1;
            case (funct)
                6'b100000: dec_next.ctrl = 4'b0000;
                6'b100100: dec_next.ctrl = 4'b0101;
                6'b100111: dec_next.ctrl = 4'b0111;
                6'b000000: begin
                    dec_next.ctrl = 4'b0100;
                    dec_next.a    = rt_data;
                    dec_next.b    = zext_shamt;
                end
                default:   legal_next = 1'b0;
            endcase
        end else begin
            dec_next.a    = rs_data;
            dec_next.b    = sext_imm;
            dec_next.dest = rt_idx;
            dec_next.wr   = 1'b1;
            legal_next    = 1'b1;
            case (opcode)
                6'b001000: dec_next.ctrl = 4'b0001;
                6'b001100: begin
                    dec_next.ctrl = 4'b0110;
                    dec_next.b    = zext_imm;
                end
                6'b100011: begin
                    dec_next.ctrl = 4'b0010;
                    dec_next.rd   = 1'b1;
                end
                6'b101011: begin
                    dec_next.ctrl = 4'b0011;
                    dec_next.sd   = rt_data;
                    dec_next.dest = 5'd0;
                    dec_next.wr   = 1'b0;
                    dec_next.mw   = 1'b1;
                end
                default:   legal_next = 1'b0;
            endcase
        end
        // Writes to $0 are architecturally discarded.
        if (dec_next.dest == 5'd0) begin
            dec_next.wr = 1'b0;
        end
    end

`ifdef ALU_ISSUE_TRAP_EN
    assign in_ready = (state_reg != FULL) && !illegal_reg;
`else
    assign in_ready = (state_reg != FULL);
`endif

    assign out_valid = (state_reg != EMPTY);
    assign fire_in   = in_valid && in_ready;
    assign accept    = fire_in && legal_next;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= EMPTY;
            illegal_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i] <= '0;
            end
        end else begin
`ifdef ALU_ISSUE_TRAP_EN
            if (fire_in && !legal_next) begin
                illegal_reg <= 1'b1;
            end
`else
            illegal_reg <= fire_in && !legal_next;
`endif
            // Drained slots are zeroed so idle outputs read as 0.
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        ent_reg[0] <= dec_next;
                        state_reg  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        ent_reg[0] <= dec_next;
                    end else if (accept) begin
                        ent_reg[1] <= dec_next;
                        state_reg  <= FULL;
                    end else if (drain) begin
                        ent_reg[0] <= '0;
                        state_reg  <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        ent_reg[0] <= ent_reg[1];
                        ent_reg[1] <= '0;
                        state_reg  <= ONE;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

    assign control_in = ent_reg[0].ctrl;
    assign in1        = ent_reg[0].a;
    assign in2        = ent_reg[0].b;
    assign store_data = ent_reg[0].sd;
    assign dest_reg   = ent_reg[0].dest;
    assign reg_wr     = ent_reg[0].wr;
    assign mem_rd     = ent_reg[0].rd;
    assign mem_wr     = ent_reg[0].mw;
    assign illegal    = illegal_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; expected values are hand-decoded from the instruction words.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  control_in;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;

    int n_cmp;
    int n_err;

    alu_issue_stage #(.DATA_W(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .out_valid(out_valid), .out_ready(out_ready), .control_in(control_in),
        .in1(in1), .in2(in2), .store_data(store_data), .dest_reg(dest_reg),
        .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        instr    = w;
        rs_data  = a;
        rt_data  = b;
        in_valid = 1'b1;
        $display("xfer instr=%h rs=%h rt=%h in_ready=%b", w, a, b, in_ready);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_data = '0; rt_data = '0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal got %b want 0", illegal); end
        n_cmp++; if ({control_in, in1, in2, reg_wr} !== '0) begin n_err++; $display("FAIL rst_fields got %h/%h/%h/%b want 0", control_in, in1, in2, reg_wr); end
        idle();
        idle();
        rst = 1'b0;
        idle();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        send(32'h0022_1820, 32'd5, 32'd7);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", out_valid); end
        n_cmp++; if (control_in !== 4'b0000) begin n_err++; $display("FAIL add_ctrl got %b want 0000", control_in); end
        n_cmp++; if (in1 !== 32'd5 || in2 !== 32'd7) begin n_err++; $display("FAIL add_ops got %h,%h want 5,7", in1, in2); end
        n_cmp++; if (dest_reg !== 5'd3 || reg_wr !== 1'b1) begin n_err++; $display("FAIL add_dest got %0d,%b want 3,1", dest_reg, reg_wr); end
        idle();
        n_cmp++; if (out_valid !== 1'b0 || in1 !== 32'd0) begin n_err++; $display("FAIL add_drain got %b,%h want 0,0", out_valid, in1); end
    endtask

    task automatic test_imm();
        out_ready = 1'b1;
        send(32'h2024_FFFF, 32'd10, 32'd0);
        n_cmp++; if (control_in !== 4'b0001 || in1 !== 32'd10) begin n_err++; $display("FAIL addi_ctrl got %b,%h want 0001,a", control_in, in1); end
        n_cmp++; if (in2 !== 32'hFFFF_FFFF || dest_reg !== 5'd4) begin n_err++; $display("FAIL addi_imm got %h,%0d want ffffffff,4", in2, dest_reg); end
        send(32'h3025_FFFF, 32'd1, 32'd0);
        n_cmp++; if (control_in !== 4'b0110 || in2 !== 32'h0000_FFFF) begin n_err++; $display("FAIL andi got %b,%h want 0110,0000ffff", control_in, in2); end
        send(32'h8C26_0004, 32'h40, 32'd0);
        n_cmp++; if (control_in !== 4'b0010 || mem_rd !== 1'b1 || in2 !== 32'd4 || reg_wr !== 1'b1 || dest_reg !== 5'd6) begin
            n_err++; $display("FAIL lw got %b,%b,%h,%b,%0d want 0010,1,4,1,6", control_in, mem_rd, in2, reg_wr, dest_reg); end
        send(32'h0002_3900, 32'd99, 32'h1234);
        n_cmp++; if (control_in !== 4'b0100 || in1 !== 32'h1234 || in2 !== 32'd4 || dest_reg !== 5'd7) begin
            n_err++; $display("FAIL sll got %b,%h,%h,%0d want 0100,1234,4,7", control_in, in1, in2, dest_reg); end
        send(32'h0022_0020, 32'd1, 32'd2);
        n_cmp++; if (control_in !== 4'b0000 || reg_wr !== 1'b0) begin n_err++; $display("FAIL add_r0 got %b,%b want 0000,0", control_in, reg_wr); end
        idle();
    endtask

    task automatic test_sw();
        out_ready = 1'b1;
        send(32'hAC22_0008, 32'h100, 32'hAB);
        n_cmp++; if (control_in !== 4'b0011 || in1 !== 32'h100 || in2 !== 32'd8) begin n_err++; $display("FAIL sw_ops got %b,%h,%h want 0011,100,8", control_in, in1, in2); end
        n_cmp++; if (store_data !== 32'hAB || mem_wr !== 1'b1 || reg_wr !== 1'b0 || mem_rd !== 1'b0) begin
            n_err++; $display("FAIL sw_ctl got %h,%b,%b,%b want ab,1,0,0", store_data, mem_wr, reg_wr, mem_rd); end
        idle();
        n_cmp++; if (store_data !== 32'd0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL sw_idle got %h,%b want 0,0", store_data, mem_wr); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        rs_data = 32'd1; rt_data = 32'd2; in_valid = 1'b1;
        instr = 32'h0022_1820;
        $display("xfer instr=%h (held, out_ready=0)", instr);
        idle();
        instr = 32'h0022_2024;
        $display("xfer instr=%h (held, out_ready=0)", instr);
        idle();
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_full got %b,%b want 0,1", in_ready, out_valid); end
        instr = 32'h0022_2827;
        $display("xfer instr=%h (offered while full)", instr);
        idle();
        n_cmp++; if (control_in !== 4'b0000 || in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_hold got %b,%b want 0000,0", control_in, in_ready); end
        out_ready = 1'b1;
        idle();
        n_cmp++; if (control_in !== 4'b0101 || dest_reg !== 5'd4 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_and got %b,%0d,%b want 0101,4,1", control_in, dest_reg, in_ready); end
        idle();
        in_valid = 1'b0;
        n_cmp++; if (control_in !== 4'b0111 || dest_reg !== 5'd5 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_nor got %b,%0d,%b want 0111,5,1", control_in, dest_reg, out_valid); end
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        send(32'h0022_1820, 32'd1, 32'd2);
        send(32'hFC00_0000, 32'd1, 32'd2);
        n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL ill_set got %b want 1", illegal); end
`ifdef ALU_ISSUE_TRAP_EN
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ill_stall got %b want 0", in_ready); end
        send(32'h0022_2024, 32'd1, 32'd2);
        n_cmp++; if (illegal !== 1'b1 || in_ready !== 1'b0 || control_in !== 4'b0000) begin
            n_err++; $display("FAIL ill_sticky got %b,%b,%b want 1,0,0000", illegal, in_ready, control_in); end
        out_ready = 1'b1;
        idle();
        n_cmp++; if (out_valid !== 1'b0 || illegal !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL ill_drain got %b,%b,%b want 0,1,0", out_valid, illegal, in_ready); end
`else
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL ill_noenq got %b,%b want 1,1", in_ready, out_valid); end
        send(32'h0022_2024, 32'd1, 32'd2);
        n_cmp++; if (illegal !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL ill_pulse got %b,%b want 0,0", illegal, in_ready); end
        n_cmp++; if (control_in !== 4'b0000) begin n_err++; $display("FAIL ill_head got %b want 0000", control_in); end
        out_ready = 1'b1;
        idle();
        n_cmp++; if (control_in !== 4'b0101 || out_valid !== 1'b1) begin n_err++; $display("FAIL ill_second got %b,%b want 0101,1", control_in, out_valid); end
        idle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ill_count got %b want 0", out_valid); end
`endif
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        out_ready = 1'b0;
        send(32'h0022_1820, 32'd1, 32'd2);
        send(32'h0022_2024, 32'd1, 32'd2);
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL rm_full got %b,%b want 0,1", in_ready, out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || control_in !== 4'b0000 || in1 !== 32'd0) begin
            n_err++; $display("FAIL rm_async got %b,%b,%b,%h want 0,1,0000,0", out_valid, in_ready, control_in, in1); end
        #1;
        rst = 1'b0;
        idle();
        out_ready = 1'b1;
        send(32'h2024_FFFF, 32'd10, 32'd0);
        n_cmp++; if (control_in !== 4'b0001 || in1 !== 32'd10 || in2 !== 32'hFFFF_FFFF || dest_reg !== 5'd4) begin
            n_err++; $display("FAIL rm_post got %b,%h,%h,%0d want 0001,a,ffffffff,4", control_in, in1, in2, dest_reg); end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_add();
        test_imm();
        test_sw();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
